// File: rtl/d_trigger.sv
// d_trigger: positive-edge D flip-flop with complementary outputs and an
// asynchronous active-low clear. Each bit is a master-slave pair of level
// sensitive latches: the master follows D while C is low, and the slave
// follows the master while C is high. Together they capture D on the rising
// edge of C.
//
// Optional feature: define D_TRIGGER_SET_EN to add Sn, an asynchronous
// active-low set. When Rn and Sn are both low, reset wins.
//
// Reset forces both latches to 0. Suppose Rn is released at the same instant
// as a rising edge of C. The master then holds its forced 0 because C is
// already high, so the slave copies that 0 and the edge is ignored. Capture
// resumes at the next rising edge.
module d_trigger #(
    parameter int WIDTH = 1
) (
    input  logic             C,
    input  logic             Rn,
`ifdef D_TRIGGER_SET_EN
    input  logic             Sn,
`endif
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    // Master stage: transparent while C=0, holds while C=1.
    logic [WIDTH-1:0] master_q;
    // Slave stage: transparent while C=1, holds while C=0.
    logic [WIDTH-1:0] slave_q;
    // Value the master passes on when it is transparent.
    logic [WIDTH-1:0] master_d;
    // Value the slave passes on when it is transparent.
    logic [WIDTH-1:0] slave_d;

    assign master_d = D;
    assign slave_d  = master_q;

`ifdef D_TRIGGER_SET_EN
    // Master latch: clear has priority over set; otherwise follow D while C is low.
    always_latch begin
        if (!Rn) begin
            master_q <= '0;
        end else if (!Sn) begin
            master_q <= '1;
        end else if (!C) begin
            master_q <= master_d;
        end
    end

    // Slave latch: clear has priority over set; otherwise follow master while C is high.
    always_latch begin
        if (!Rn) begin
            slave_q <= '0;
        end else if (!Sn) begin
            slave_q <= '1;
        end else if (C) begin
            slave_q <= slave_d;
        end
    end
`else
    // Master latch: forced to 0 by clear; otherwise follow D while C is low.
    always_latch begin
        if (!Rn) begin
            master_q <= '0;
        end else if (!C) begin
            master_q <= master_d;
        end
    end

    // Slave latch: forced to 0 by clear; otherwise follow master while C is high.
    always_latch begin
        if (!Rn) begin
            slave_q <= '0;
        end else if (C) begin
            slave_q <= slave_d;
        end
    end
`endif

    // Both outputs come from the slave, so Qn is always the exact complement of Q.
    assign Q  = slave_q;
    assign Qn = ~slave_q;

endmodule

// File: tb/tb_d_trigger.sv
// tb_d_trigger: directed checks of d_trigger. The bench drives one 1-bit
// instance and one 4-bit instance from a shared C and Rn.
// Every comparison is an immediate assertion. The bench samples 1 ns or more
// after each stimulus change.
`timescale 1ns/1ps
module tb_d_trigger;

    logic       c;
    logic       rn;
`ifdef D_TRIGGER_SET_EN
    logic       sn;
`endif
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] qn1;
    logic [3:0] d4;
    logic [3:0] q4;
    logic [3:0] qn4;

    int errors = 0;
    int checks = 0;

    d_trigger #(.WIDTH(1)) dut1 (
        .C  (c),
        .Rn (rn),
`ifdef D_TRIGGER_SET_EN
        .Sn (sn),
`endif
        .D  (d1),
        .Q  (q1),
        .Qn (qn1)
    );

    d_trigger #(.WIDTH(4)) dut4 (
        .C  (c),
        .Rn (rn),
`ifdef D_TRIGGER_SET_EN
        .Sn (sn),
`endif
        .D  (d4),
        .Q  (q4),
        .Qn (qn4)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Compare both instances against the expected Q. Each Qn is also compared
    // against its hand-computed complement.
    task automatic check_all(input string tag, input logic e1, input logic [3:0] e4);
        check({tag, " q1"},  {3'b000, q1},  {3'b000, e1});
        check({tag, " qn1"}, {3'b000, qn1}, {3'b000, ~e1});
        check({tag, " q4"},  q4,  e4);
        check({tag, " qn4"}, qn4, ~e4);
    endtask

    initial begin
        // Reset held with C toggling and D=1: outputs stay cleared.
        c  = 1'b0;
        rn = 1'b0;
`ifdef D_TRIGGER_SET_EN
        sn = 1'b1;
`endif
        d1 = 1'b1;
        d4 = 4'b1111;
        #5;  check_all("reset_c0", 1'b0, 4'b0000);
        c = 1'b1; #10; check_all("reset_rise1", 1'b0, 4'b0000);
        c = 1'b0; #10;
        c = 1'b1; #10; check_all("reset_rise2", 1'b0, 4'b0000);
        c = 1'b0; #10;

        // Release reset with C low: Q stays 0 until the next rising edge.
        rn = 1'b1; #10; check_all("release_c0", 1'b0, 4'b0000);

        // Clocked capture: D=0 then D=1, alternating, one change per cycle.
        d1 = 1'b0; d4 = 4'b1010; #10;
        c = 1'b1; #1; check_all("cap_0", 1'b0, 4'b1010);
        #39; c = 1'b0; #10;
        d1 = 1'b1; d4 = 4'b0110; #40;
        c = 1'b1; #1; check_all("cap_1", 1'b1, 4'b0110);
        #39; c = 1'b0; #10;
        d1 = 1'b0; d4 = 4'b0001; #40;
        c = 1'b1; #1; check_all("cap_2", 1'b0, 4'b0001);
        #39; c = 1'b0; #10;
        d1 = 1'b1; d4 = 4'b1000; #40;
        c = 1'b1; #1; check_all("cap_3", 1'b1, 4'b1000);
        #39; c = 1'b0; #10;

        // Capture 0, then pulse D high while C is high: Q must not change.
        d1 = 1'b0; d4 = 4'b0000; #40;
        c = 1'b1; #1; check_all("cap_low", 1'b0, 4'b0000);
        #9; d1 = 1'b1; d4 = 4'b1111; #10;
        check_all("d_glitch_high", 1'b0, 4'b0000);
        d1 = 1'b0; d4 = 4'b0000; #10;
        c = 1'b0; #1; check_all("fall_no_cap", 1'b0, 4'b0000);

        // D changes while C is static low are ignored.
        #9; d1 = 1'b1; d4 = 4'b0101; #20;
        check_all("c_static_low", 1'b0, 4'b0000);
        c = 1'b1; #1; check_all("cap_after_static", 1'b1, 4'b0101);

        // A short reset pulse in mid-cycle clears Q immediately.
        #19; rn = 1'b0; #1; check_all("rst_pulse_now", 1'b0, 4'b0000);
        #9; rn = 1'b1; #1; check_all("rst_pulse_after", 1'b0, 4'b0000);
        #19; c = 1'b0; #1; check_all("rst_pulse_fall", 1'b0, 4'b0000);
        #39; c = 1'b1; #1; check_all("rst_recover", 1'b1, 4'b0101);
        #39; c = 1'b0; #10;

        // Reset released at the same instant as a rising edge: that edge is ignored.
        rn = 1'b0; #10;
        d1 = 1'b1; d4 = 4'b1100; #10;
        rn = 1'b1; c = 1'b1; #1; check_all("coincident_release", 1'b0, 4'b0000);
        #39; c = 1'b0; #10;
        c = 1'b1; #1; check_all("after_coincident", 1'b1, 4'b1100);
        #39; c = 1'b0; #10;

`ifdef D_TRIGGER_SET_EN
        // Set forces all ones; clear beats set; capture resumes after release.
        d1 = 1'b0; d4 = 4'b0000; #10;
        sn = 1'b0; #1; check_all("set_only", 1'b1, 4'b1111);
        #9; rn = 1'b0; #1; check_all("set_and_reset", 1'b0, 4'b0000);
        #9; rn = 1'b1; sn = 1'b1; #10;
        c = 1'b1; #1; check_all("after_set_reset", 1'b0, 4'b0000);
        #39; c = 1'b0; #10;
        sn = 1'b0; #10; sn = 1'b1; #10;
        check_all("set_release_hold", 1'b1, 4'b1111);
        c = 1'b1; #1; check_all("set_release_cap", 1'b0, 4'b0000);
        #39; c = 1'b0; #10;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
